gelato_inst_decoder: RTL and testbench
======================================

Name: gelato_inst_decoder

Overview:
- Per-SM decode stage. Accepts fetched 32-bit RV32I and Gelato custom instruction words tagged with warp number and PC.
- Decodes each word into the packed decoded-instruction record.
- Drives the producer (master) side of gelato_idecode_ibuffer_if towards the per-warp instruction buffers.
- A 1-cycle output register plus a 1-entry skid buffer sustains full throughput under downstream backpressure.

Parameters:
- WARP_NUM, 32, number of warps per SM; WARP_ID_W = $clog2(WARP_NUM)
- XLEN, 32, instruction, PC and immediate width

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous, active-high reset (asserted at 1, despite the name)
- rdy  input  1  global enable; 0 freezes all state
- fetch_valid  input  1  fetched instruction valid
- fetch_ready  output  1  decoder can accept this cycle
- fetch_inst  input  XLEN  instruction word
- fetch_pc  input  XLEN  instruction PC
- fetch_warp  input  WARP_ID_W  issuing warp
- inst_decoded_data  interface  gelato_idecode_ibuffer_if.master  fields:
  - valid (out)
  - ready (in)
  - warp_num
  - pc
  - inst_type (4b)
  - alu_op (4b)
  - rd, rs1, rs2 (5b each)
  - imm (32b)
  - rd_we
  - illegal

Behaviour:
- Reset: out valid=0 and all record fields 0; skid empty; fetch_ready=1 once reset deasserts.
- Acceptance:
  - Fetch handshake completes when fetch_valid & fetch_ready & rdy.
  - fetch_ready = rdy & ~skid_full.
- Latency: the decoded record appears on the interface the cycle after acceptance, from a registered output with no combinational path from fetch_inst.
- Output handshake:
  - A transfer completes when valid & ready.
  - While valid=1 and ready=0, the record is held stable.
  - valid never drops without a transfer, except on reset.
- Skid buffer:
  - Entry condition: an accepted instruction arrives while the output register holds an un-transferred record.
  - While the skid is full, fetch_ready=0.
  - When the output transfers, the skid entry moves to the output register the same cycle.
  - A new acceptance in that same cycle writes the now-empty skid. It cannot, because fetch_ready was 0; the skid re-arms the following cycle.
  - Order is strictly preserved.
- Simultaneous output transfer and fetch acceptance with the skid empty: the new record loads directly into the output register. valid stays 1 and there is no bubble.
- rdy=0:
  - No register updates and no acceptance.
  - valid and fields hold.
  - A downstream ready seen while rdy=0 does not count as a transfer.
- Decode rules, by opcode[6:0]:
  - LUI 0110111: imm = {inst[31:12], 12'b0}
  - AUIPC 0010111: same immediate as LUI
  - JAL 1101111: J-immediate, sign-extended
  - JALR 1100111: I-immediate
  - BRANCH 1100011: B-immediate, sign-extended, rd_we=0
  - LOAD 0000011: I-immediate
  - STORE 0100011: S-immediate, rd_we=0
  - OP-IMM 0010011: I-immediate; shifts use imm = shamt inst[24:20], zero-extended
  - OP 0110011: imm = 0
  - CUSTOM0 0001011: SIMT control (split/join/barrier, selected by funct3); rd_we=0
- alu_op: from funct3 plus inst[30] for OP, and for OP-IMM SRAI. Branches map to compare ops.
- rd_we = 0 when rd = 0.
- Illegal cases: any other opcode, or an undefined funct3/funct7 combination.
  - Result: illegal=1, rd_we=0, inst_type=ILLEGAL, other fields 0.
  - The record is still forwarded so the buffer can trap.
- Reset mid-operation: output and skid contents are discarded immediately (asynchronous); no partial transfer is replayed.

Decomposition:
- Shared package gelato_types_pkg:
  - inst_type_e enum (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ALU_IMM, ALU_REG, SIMT, ILLEGAL)
  - alu_op_e enum
  - opcode localparams
  - decoded_inst_t packed struct, reused by the interface and gelato_warp_inst_buffer
- Sub-module gelato_inst_decode_comb: purely combinational, instruction word -> decoded_inst_t.
- The top level holds the output register, skid and handshake.

Test Plan:
- ADDI x1,x0,5 (0x00500093), warp 3, ready=1 -> next cycle: valid=1, warp_num=3, inst_type=ALU_IMM, alu_op=ADD, rd=1, rs1=0, imm=0x00000005, rd_we=1.
- LUI x2,0x12345 (0x12345137) -> imm=0x12345000, rd=2, rd_we=1. Then BEQ x1,x2,-4 (0xFE208EE3) -> imm=0xFFFFFFFC, rs1=1, rs2=2, rd_we=0.
- Three back-to-back fetches with ready held 0 for 3 cycles:
  - The first fills the output, the second fills the skid.
  - fetch_ready=0 and the third is stalled.
  - On release, all three emerge in order on consecutive cycles.
- 0xFFFFFFFF, then ADDI x0,x0,0 (0x00000013):
  - First -> illegal=1, rd_we=0.
  - Second -> legal, rd=0, rd_we=0.
- rdy=0 for 2 cycles with valid=1 and ready=1 -> no transfer and the record holds. After rdy returns to 1, exactly one transfer occurs.
- Assert rst_n with the output and skid both full -> valid=0 and fetch_ready=0 while asserted. After deassertion, fetch_ready=1 and no stale records appear.

Source files
------------

// File: rtl/gelato_types_pkg.sv
// Shared decode types: instruction classes, ALU op encodings, opcodes and the
// decoded-instruction record carried from decode to the per-warp buffers.
package gelato_types_pkg;

   typedef enum logic [3:0] {
      LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ALU_IMM, ALU_REG, SIMT, ILLEGAL
   } inst_type_e;

   // Branch ops produce "taken" as a nonzero result, so BNE reuses XOR.
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
      ALU_OR, ALU_AND, ALU_SEQ, ALU_SGE, ALU_SGEU, ALU_SPLIT, ALU_JOIN, ALU_BAR
   } alu_op_e;

   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

   typedef struct packed {
      inst_type_e  inst_type;
      alu_op_e     alu_op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic        rd_we;
      logic        illegal;
   } decoded_inst_t;

   function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/gelato_idecode_ibuffer_if.sv
// Decode -> instruction-buffer link: valid/ready handshake plus warp, PC and
// the decoded record.
interface gelato_idecode_ibuffer_if
   import gelato_types_pkg::*;
#(
   parameter int WARP_NUM = 32,
   parameter int XLEN     = 32
);
   localparam int WARP_ID_W = $clog2(WARP_NUM);

   logic                 valid;
   logic                 ready;
   logic [WARP_ID_W-1:0] warp_num;
   logic [XLEN-1:0]      pc;
   decoded_inst_t        inst;

   modport master (output valid, warp_num, pc, inst, input ready);
   modport slave  (input valid, warp_num, pc, inst, output ready);
endinterface

// File: rtl/gelato_inst_decode_comb.sv
// Combinational RV32I + Gelato SIMT decoder: instruction word -> decoded record.
module gelato_inst_decode_comb
   import gelato_types_pkg::*;
(
   input  logic [31:0]   inst,
   output decoded_inst_t dec
);
   logic [6:0]  opc, f7;
   logic [2:0]  f3;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        ok, wr;
   decoded_inst_t r;

   assign opc   = inst[6:0];
   assign rd    = inst[11:7];
   assign f3    = inst[14:12];
   assign rs1   = inst[19:15];
   assign rs2   = inst[24:20];
   assign f7    = inst[31:25];
   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {inst[31:12], 12'b0};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   // Register fields a format does not use are zeroed, not passed through.
   always_comb begin
      r  = '0;
      ok = 1'b1;
      wr = 1'b0;
      case (opc)
         OPC_LUI:   begin r.inst_type = LUI;   r.rd = rd; r.imm = imm_u; wr = 1'b1; end
         OPC_AUIPC: begin r.inst_type = AUIPC; r.rd = rd; r.imm = imm_u; wr = 1'b1; end
         OPC_JAL:   begin r.inst_type = JAL;   r.rd = rd; r.imm = imm_j; wr = 1'b1; end
         OPC_JALR: begin
            r.inst_type = JALR; r.rd = rd; r.rs1 = rs1; r.imm = imm_i; wr = 1'b1;
            ok = (f3 == 3'b000);
         end
         OPC_BRANCH: begin
            r.inst_type = BRANCH; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm_b;
            case (f3)
               3'b000:  r.alu_op = ALU_SEQ;
               3'b001:  r.alu_op = ALU_XOR;
               3'b100:  r.alu_op = ALU_SLT;
               3'b101:  r.alu_op = ALU_SGE;
               3'b110:  r.alu_op = ALU_SLTU;
               3'b111:  r.alu_op = ALU_SGEU;
               default: ok = 1'b0;
            endcase
         end
         OPC_LOAD: begin
            r.inst_type = LOAD; r.rd = rd; r.rs1 = rs1; r.imm = imm_i; wr = 1'b1;
            ok = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
         end
         OPC_STORE: begin
            r.inst_type = STORE; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm_s;
            ok = f3 inside {3'b000, 3'b001, 3'b010};
         end
         OPC_OP_IMM: begin
            r.inst_type = ALU_IMM; r.rd = rd; r.rs1 = rs1; wr = 1'b1;
            if (f3 == 3'b001 || f3 == 3'b101) begin
               r.imm    = {27'b0, inst[24:20]};
               r.alu_op = alu_from_f3(f3, inst[30]);
               ok       = (f7 == 7'b0000000) || (f3 == 3'b101 && f7 == 7'b0100000);
            end else begin
               r.imm    = imm_i;
               r.alu_op = alu_from_f3(f3, 1'b0);
            end
         end
         OPC_OP: begin
            r.inst_type = ALU_REG; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; wr = 1'b1;
            r.alu_op = alu_from_f3(f3, inst[30]);
            ok = (f7 == 7'b0000000) ||
                 (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
         end
         OPC_CUSTOM0: begin
            r.inst_type = SIMT; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm_i;
            case (f3)
               3'b000:  r.alu_op = ALU_SPLIT;
               3'b001:  r.alu_op = ALU_JOIN;
               3'b010:  r.alu_op = ALU_BAR;
               default: ok = 1'b0;
            endcase
         end
         default: ok = 1'b0;
      endcase
      r.rd_we = wr && (rd != 5'd0);
      if (!ok) begin
         r           = '0;
         r.inst_type = ILLEGAL;
         r.illegal   = 1'b1;
      end
   end

   assign dec = r;

endmodule

// File: rtl/gelato_inst_decoder.sv
// Per-SM decode stage: registered decoded output plus a one-entry skid so the
// fetch side keeps full throughput while the instruction buffer backpressures.
module gelato_inst_decoder
   import gelato_types_pkg::*;
#(
   parameter  int WARP_NUM  = 32,
   parameter  int XLEN      = 32,
   localparam int WARP_ID_W = $clog2(WARP_NUM)
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rdy,
   input  logic                 fetch_valid,
   output logic                 fetch_ready,
   input  logic [XLEN-1:0]      fetch_inst,
   input  logic [XLEN-1:0]      fetch_pc,
   input  logic [WARP_ID_W-1:0] fetch_warp,
   gelato_idecode_ibuffer_if.master inst_decoded_data
);
   typedef struct packed {
      logic [WARP_ID_W-1:0] warp;
      logic [XLEN-1:0]      pc;
      decoded_inst_t        rec;
   } entry_t;

   decoded_inst_t dec;
   entry_t        dec_e, out_q, sk_q;
   logic          out_vld, sk_full, accept, xfer;

   gelato_inst_decode_comb u_dec (
      .inst (fetch_inst[31:0]),
      .dec  (dec)
   );

   assign dec_e = '{warp: fetch_warp, pc: fetch_pc, rec: dec};

   // rst_n is the active-high reset; fetch is refused while it is held.
   assign fetch_ready = rdy & ~sk_full & ~rst_n;
   assign accept      = fetch_valid & fetch_ready;
   assign xfer        = out_vld & inst_decoded_data.ready;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         out_vld <= 1'b0;
         out_q   <= '0;
         sk_full <= 1'b0;
         sk_q    <= '0;
      end else if (rdy) begin
         if (xfer) begin
            // Skid drains first to keep order; accept cannot coincide since fetch_ready=0.
            if (sk_full) begin
               out_q   <= sk_q;
               sk_full <= 1'b0;
            end else if (accept) begin
               out_q   <= dec_e;
            end else begin
               out_vld <= 1'b0;
            end
         end else if (accept) begin
            if (out_vld) begin
               sk_q    <= dec_e;
               sk_full <= 1'b1;
            end else begin
               out_q   <= dec_e;
               out_vld <= 1'b1;
            end
         end
      end
   end

   assign inst_decoded_data.valid    = out_vld;
   assign inst_decoded_data.warp_num = out_q.warp;
   assign inst_decoded_data.pc       = out_q.pc;
   assign inst_decoded_data.inst     = out_q.rec;

endmodule

// File: tb/tb_gelato_inst_decoder.sv
// Directed bench for gelato_inst_decoder: decode vectors, skid backpressure,
// rdy freeze and mid-operation reset.
module tb_gelato_inst_decoder;
   import gelato_types_pkg::*;

   logic        clk, rst_n, rdy, fetch_valid, fetch_ready;
   logic [31:0] fetch_inst, fetch_pc;
   logic [4:0]  fetch_warp;
   int          checks = 0, failures = 0, xfers = 0, x0;
   logic [31:0]   vin  [6];
   decoded_inst_t vexp [6];

   gelato_idecode_ibuffer_if #(.WARP_NUM(32), .XLEN(32)) ib ();

   gelato_inst_decoder #(.WARP_NUM(32), .XLEN(32)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .rdy               (rdy),
      .fetch_valid       (fetch_valid),
      .fetch_ready       (fetch_ready),
      .fetch_inst        (fetch_inst),
      .fetch_pc          (fetch_pc),
      .fetch_warp        (fetch_warp),
      .inst_decoded_data (ib)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk)
      if (!rst_n && rdy && ib.valid && ib.ready) xfers++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic decoded_inst_t mk(input inst_type_e t, input alu_op_e op,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] imm,
                                        input logic we, input logic ill);
      mk = '{inst_type: t, alu_op: op, rd: rd, rs1: rs1, rs2: rs2, imm: imm,
             rd_we: we, illegal: ill};
   endfunction

   task automatic chk_out(input string tag, input logic [4:0] w, input logic [31:0] pc,
                          input decoded_inst_t rec);
      chk({tag, "_valid"}, 64'(ib.valid), 64'd1);
      chk({tag, "_warp"},  64'(ib.warp_num), 64'(w));
      chk({tag, "_pc"},    64'(ib.pc), 64'(pc));
      chk({tag, "_rec"},   64'(ib.inst), 64'(rec));
   endtask

   task automatic fetch(input logic [31:0] inst, input logic [4:0] w, input logic [31:0] pc);
      fetch_valid = 1'b1;
      fetch_inst  = inst;
      fetch_warp  = w;
      fetch_pc    = pc;
   endtask

   initial begin
      rst_n = 1'b1; rdy = 1'b1; fetch_valid = 1'b0; fetch_inst = '0;
      fetch_pc = '0; fetch_warp = '0; ib.ready = 1'b1;
      tick(); tick();
      chk("rst_valid",  64'(ib.valid), 64'd0);
      chk("rst_fready", 64'(fetch_ready), 64'd0);
      chk("rst_rec",    64'(ib.inst), 64'd0);
      chk("rst_pc",     64'(ib.pc), 64'd0);
      rst_n = 1'b0;
      #1;
      chk("post_rst_fready", 64'(fetch_ready), 64'd1);

      // ADDI x1,x0,5 ; LUI x2,0x12345 ; BEQ x1,x2,-4 back to back, ready held 1
      fetch(32'h0050_0093, 5'd3, 32'h100);
      tick();
      chk_out("addi", 5'd3, 32'h100, mk(ALU_IMM, ALU_ADD, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 1'b0));
      fetch(32'h1234_5137, 5'd1, 32'h104);
      tick();
      chk_out("lui", 5'd1, 32'h104, mk(LUI, ALU_ADD, 5'd2, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 1'b0));
      fetch(32'hFE20_8EE3, 5'd1, 32'h108);
      tick();
      chk_out("beq", 5'd1, 32'h108, mk(BRANCH, ALU_SEQ, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0, 1'b0));
      fetch_valid = 1'b0;
      tick();
      chk("drain_valid", 64'(ib.valid), 64'd0);

      // Backpressure: ADD, SUB, SRAI with ready low for three cycles
      ib.ready = 1'b0;
      fetch(32'h0020_81B3, 5'd2, 32'h200);
      tick();
      chk("bp_fready1", 64'(fetch_ready), 64'd1);
      fetch(32'h4020_8233, 5'd2, 32'h204);
      tick();
      chk("bp_fready2", 64'(fetch_ready), 64'd0);
      chk_out("bp_hold1", 5'd2, 32'h200, mk(ALU_REG, ALU_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 1'b0));
      fetch(32'h4030_D293, 5'd2, 32'h208);
      tick();
      chk("bp_fready3", 64'(fetch_ready), 64'd0);
      chk_out("bp_hold2", 5'd2, 32'h200, mk(ALU_REG, ALU_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 1'b0));
      ib.ready = 1'b1;
      tick();
      chk_out("bp_sub", 5'd2, 32'h204, mk(ALU_REG, ALU_SUB, 5'd4, 5'd1, 5'd2, 32'd0, 1'b1, 1'b0));
      chk("bp_fready4", 64'(fetch_ready), 64'd1);
      tick();
      chk_out("bp_srai", 5'd2, 32'h208, mk(ALU_IMM, ALU_SRA, 5'd5, 5'd1, 5'd0, 32'd3, 1'b1, 1'b0));
      fetch_valid = 1'b0;
      tick();
      chk("bp_empty", 64'(ib.valid), 64'd0);

      // Decode table: illegal word, NOP, bad OP funct7, SIMT barrier, JAL, SW
      vin[0] = 32'hFFFF_FFFF; vexp[0] = mk(ILLEGAL, ALU_ADD, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1);
      vin[1] = 32'h0000_0013; vexp[1] = mk(ALU_IMM, ALU_ADD, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0);
      vin[2] = 32'h4020_9233; vexp[2] = mk(ILLEGAL, ALU_ADD, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1);
      vin[3] = 32'h0000_A00B; vexp[3] = mk(SIMT, ALU_BAR, 5'd0, 5'd1, 5'd0, 32'd0, 1'b0, 1'b0);
      vin[4] = 32'h0080_00EF; vexp[4] = mk(JAL, ALU_ADD, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1, 1'b0);
      vin[5] = 32'h0020_A223; vexp[5] = mk(STORE, ALU_ADD, 5'd0, 5'd1, 5'd2, 32'd4, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         fetch(vin[i], 5'(i), 32'h300 + 32'(4 * i));
         tick();
         chk_out($sformatf("tbl%0d", i), 5'(i), 32'h300 + 32'(4 * i), vexp[i]);
      end
      fetch_valid = 1'b0;
      tick();

      // rdy=0 freezes state and masks the downstream handshake
      ib.ready = 1'b0;
      fetch(32'h0070_0313, 5'd6, 32'h400);
      tick();
      fetch_valid = 1'b0;
      rdy = 1'b0;
      ib.ready = 1'b1;
      x0 = xfers;
      tick();
      chk_out("frz1", 5'd6, 32'h400, mk(ALU_IMM, ALU_ADD, 5'd6, 5'd0, 5'd0, 32'd7, 1'b1, 1'b0));
      chk("frz_fready", 64'(fetch_ready), 64'd0);
      tick();
      chk_out("frz2", 5'd6, 32'h400, mk(ALU_IMM, ALU_ADD, 5'd6, 5'd0, 5'd0, 32'd7, 1'b1, 1'b0));
      chk("frz_no_xfer", 64'(xfers - x0), 64'd0);
      rdy = 1'b1;
      tick();
      chk("frz_release_valid", 64'(ib.valid), 64'd0);
      chk("frz_one_xfer", 64'(xfers - x0), 64'd1);
      tick();
      chk("frz_still_one", 64'(xfers - x0), 64'd1);

      // Reset with output and skid both occupied
      ib.ready = 1'b0;
      fetch(32'h0020_81B3, 5'd7, 32'h500);
      tick();
      fetch(32'h4020_8233, 5'd7, 32'h504);
      tick();
      chk("full_fready", 64'(fetch_ready), 64'd0);
      chk("full_valid", 64'(ib.valid), 64'd1);
      rst_n = 1'b1;
      fetch_valid = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(ib.valid), 64'd0);
      chk("mid_rst_fready", 64'(fetch_ready), 64'd0);
      tick();
      chk("mid_rst_valid2", 64'(ib.valid), 64'd0);
      rst_n = 1'b0;
      ib.ready = 1'b1;
      x0 = xfers;
      #1;
      chk("post_rst2_fready", 64'(fetch_ready), 64'd1);
      tick(); tick();
      chk("no_stale_valid", 64'(ib.valid), 64'd0);
      chk("no_stale_xfer", 64'(xfers - x0), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
